// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access controller for a CPU request/response
// handshake. One request in flight at a time, no queuing.
//
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   req_valid/ready     CPU request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_addr            32-bit CPU word address (latched into MAR)
//   req_wdata           store data (latched into MDR)
//   resp_valid/ready    response handshake, held until consumed
//   resp_rdata          load data, 0 for stores and errors
//   resp_err            address outside the RAM range
//   ram_read/ram_write  one-cycle RAM strobes
//   ram_address         RAM address (always the latched MAR)
//   ram_data_in         RAM write data (always the latched MDR)
//   ram_data_out        RAM read data, registered by the RAM
module mem_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CAPT,
        WR_ISSUE,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                w_accept;
    logic                w_oor;

    assign w_accept = req_valid && (r_state == IDLE);
    // Only the low ADDR_W bits reach the RAM; any upper bit set is an error.
    assign w_oor    = |req_addr[31:ADDR_W];

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. The load/store choice is carried by the
    // state itself, so no separate write-flag register is needed.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_oor) begin
                        w_next = RESP;
                    end else if (req_write) begin
                        w_next = WR_ISSUE;
                    end else begin
                        w_next = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: w_next = RD_CAPT;
            RD_CAPT:  w_next = RESP;
            WR_ISSUE: w_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    w_next = IDLE;
                end
            end
            default:  w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready  = 1'b0;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        resp_valid = 1'b0;
        unique case (r_state)
            IDLE:     req_ready  = 1'b1;
            RD_ISSUE: ram_read   = 1'b1;
            RD_CAPT:  ;
            WR_ISSUE: ram_write  = 1'b1;
            RESP:     resp_valid = 1'b1;
            default:  ;
        endcase
    end

    // MAR/MDR and response registers. Response data is cleared on
    // accept so stores and errors answer with 0 without extra muxing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mar   <= '0;
            r_mdr   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mar   <= req_addr[ADDR_W-1:0];
                r_mdr   <= req_wdata;
                r_rdata <= '0;
                r_err   <= w_oor;
            end
            if (r_state == RD_CAPT) begin
                r_rdata <= ram_data_out;
            end
        end
    end

    assign ram_address = r_mar;
    assign ram_data_in = r_mdr;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scenario tasks for mem_ctrl with a RAM model and a
// scoreboard of expected responses built from a shadow memory.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_read;
    logic        ram_write;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    typedef struct {
        int          lat;
        int          rd;
        int          wr;
        int          wait_c;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
        logic        both;
        logic        stable;
        logic        rdy_low;
        logic        rdy_after;
        logic        valid_after;
    } obs_t;

    exp_t        sb[$];
    logic [31:0] shadow [512];
    logic [31:0] mem [512];

    mem_ctrl #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_read     (ram_read),
        .ram_write    (ram_write),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
    end

    // Synchronous RAM: read data registered on the edge ending the Read cycle
    always @(posedge clk) begin
        if (ram_read) ram_data_out <= mem[ram_address];
        if (ram_write) mem[ram_address] <= ram_data_in;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Drives one request from a negedge, pushes its expectation, and
    // measures what the DUT did. Returns at a negedge after the response
    // has been consumed.
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output obs_t o);
        exp_t        e;
        logic        oor;
        logic [31:0] rd0;
        logic        er0;
        int          cyc;
        oor     = (a[31:9] != 0);
        e.err   = oor;
        e.lat   = oor ? 1 : (w ? 2 : 3);
        e.rd    = (!oor && !w) ? 1 : 0;
        e.wr    = (!oor && w) ? 1 : 0;
        e.rdata = (oor || w) ? 32'h0 : shadow[a[8:0]];
        if (!oor && w) shadow[a[8:0]] = d;
        sb.push_back(e);
        o.lat = 0; o.rd = 0; o.wr = 0; o.wait_c = 0;
        o.addr = '0; o.wd = '0; o.rdata = '0; o.err = 1'b0;
        o.both = 1'b0; o.stable = 1'b1; o.rdy_low = 1'b1;
        o.rdy_after = 1'b0; o.valid_after = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && o.wait_c < 20) begin
            @(negedge clk);
            o.wait_c++;
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~w;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        resp_ready = (hold == 0);
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            o.rd += int'(ram_read);
            o.wr += int'(ram_write);
            if (ram_read && ram_write) o.both = 1'b1;
            if (ram_read || ram_write) begin
                o.addr = ram_address;
                o.wd   = ram_data_in;
            end
            if (resp_valid) break;
        end
        o.lat   = resp_valid ? cyc : 0;
        o.rdata = resp_rdata;
        o.err   = resp_err;
        if (hold > 0) begin
            rd0 = resp_rdata;
            er0 = resp_err;
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 32'h0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!resp_valid || resp_rdata !== rd0 || resp_err !== er0)
                    o.stable = 1'b0;
                if (req_ready !== 1'b0) o.rdy_low = 1'b0;
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        o.rdy_after   = req_ready;
        o.valid_after = resp_valid;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = {resp_valid, resp_err, ram_read, ram_write} | ram_address
            | ram_data_in | resp_rdata;
        n_cmp++;
        if (v !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outs got %h exp 0", v);
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b exp 1", req_ready);
        end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset got rdy=%b vld=%b exp 1/0",
                     req_ready, resp_valid);
        end
    endtask

    task automatic test_store();
        obs_t o;
        exp_t e;
        xact(1'b1, 32'h5, 32'hDEADBEEF, 0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.lat !== e.lat) begin
            n_bad++; $display("FAIL st_lat got %0d exp %0d", o.lat, e.lat);
        end
        n_cmp++;
        if (o.wr !== e.wr || o.rd !== e.rd) begin
            n_bad++;
            $display("FAIL st_strobes got wr=%0d rd=%0d exp %0d/%0d",
                     o.wr, o.rd, e.wr, e.rd);
        end
        n_cmp++;
        if (o.addr !== 9'h005 || o.wd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL st_ram got a=%h d=%h exp 005/deadbeef",
                     o.addr, o.wd);
        end
        n_cmp++;
        if (o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++;
            $display("FAIL st_resp got %h/%b exp %h/%b",
                     o.rdata, o.err, e.rdata, e.err);
        end
    endtask

    task automatic test_load();
        obs_t o;
        exp_t e;
        xact(1'b0, 32'h5, 32'h0, 0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.lat !== e.lat) begin
            n_bad++; $display("FAIL ld_lat got %0d exp %0d", o.lat, e.lat);
        end
        n_cmp++;
        if (o.rd !== e.rd || o.wr !== e.wr || o.addr !== 9'h005) begin
            n_bad++;
            $display("FAIL ld_strobes got rd=%0d wr=%0d a=%h exp %0d/%0d/005",
                     o.rd, o.wr, o.addr, e.rd, e.wr);
        end
        n_cmp++;
        if (o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++;
            $display("FAIL ld_resp got %h/%b exp %h/%b",
                     o.rdata, o.err, e.rdata, e.err);
        end
        n_cmp++;
        if (o.both !== 1'b0) begin
            n_bad++; $display("FAIL ld_both got %b exp 0", o.both);
        end
    endtask

    task automatic test_error();
        obs_t o;
        exp_t e;
        xact(1'b0, 32'h00000200, 32'h0, 0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.lat !== e.lat) begin
            n_bad++; $display("FAIL er_lat got %0d exp %0d", o.lat, e.lat);
        end
        n_cmp++;
        if (o.err !== e.err || o.rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL er_resp got %h/%b exp %h/%b",
                     o.rdata, o.err, e.rdata, e.err);
        end
        n_cmp++;
        if (o.rd + o.wr !== 0) begin
            n_bad++;
            $display("FAIL er_strobes got %0d exp 0", o.rd + o.wr);
        end
        xact(1'b1, 32'h80000005, 32'h11111111, 0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.lat !== e.lat || o.err !== e.err || o.wr !== e.wr) begin
            n_bad++;
            $display("FAIL er_store got lat=%0d err=%b wr=%0d exp %0d/%b/%0d",
                     o.lat, o.err, o.wr, e.lat, e.err, e.wr);
        end
        xact(1'b0, 32'h5, 32'h0, 0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL er_alias got %h exp %h", o.rdata, e.rdata);
        end
    endtask

    task automatic test_stall();
        obs_t o;
        exp_t e;
        xact(1'b1, 32'h0C, 32'h12345678, 0, o);
        e = sb.pop_front();
        xact(1'b0, 32'h0C, 32'h0, 5, o);
        e = sb.pop_front();
        n_cmp++;
        if (o.rdata !== e.rdata || o.lat !== e.lat) begin
            n_bad++;
            $display("FAIL sl_resp got %h lat %0d exp %h lat %0d",
                     o.rdata, o.lat, e.rdata, e.lat);
        end
        n_cmp++;
        if (o.stable !== 1'b1) begin
            n_bad++; $display("FAIL sl_stable got %b exp 1", o.stable);
        end
        n_cmp++;
        if (o.rdy_low !== 1'b1) begin
            n_bad++; $display("FAIL sl_ready_low got %b exp 1", o.rdy_low);
        end
        n_cmp++;
        if (o.rdy_after !== 1'b1 || o.valid_after !== 1'b0) begin
            n_bad++;
            $display("FAIL sl_done got rdy=%b vld=%b exp 1/0",
                     o.rdy_after, o.valid_after);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        seen;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'hAB;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ram_read !== 1'b1 || ram_address !== 9'h0AB) begin
            n_bad++;
            $display("FAIL rm_issue got rd=%b a=%h exp 1/0ab",
                     ram_read, ram_address);
        end
        @(negedge clk);
        v = {resp_valid, resp_err, ram_read, ram_write} | ram_address
            | ram_data_in | resp_rdata;
        n_cmp++;
        if (v !== 32'h0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_outs got %h rdy %b exp 0/1", v, req_ready);
        end
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || ram_read || ram_write) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++; $display("FAIL rm_noresp got %b exp 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1;
        obs_t o2;
        exp_t e;
        xact(1'b1, 32'h1FF, 32'hA5C3_5A3C, 0, o1);
        e = sb.pop_front();
        n_cmp++;
        if (o1.rdy_after !== 1'b1 || o1.addr !== 9'h1FF) begin
            n_bad++;
            $display("FAIL bb_store got rdy=%b a=%h exp 1/1ff",
                     o1.rdy_after, o1.addr);
        end
        xact(1'b0, 32'h1FF, 32'h0, 0, o2);
        e = sb.pop_front();
        n_cmp++;
        if (o2.wait_c !== 0) begin
            n_bad++; $display("FAIL bb_wait got %0d exp 0", o2.wait_c);
        end
        n_cmp++;
        if (o2.rdata !== e.rdata || o2.lat !== e.lat) begin
            n_bad++;
            $display("FAIL bb_load got %h lat %0d exp %h lat %0d",
                     o2.rdata, o2.lat, e.rdata, e.lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = '0;
        @(negedge clk);
        test_reset();
        test_store();
        test_load();
        test_error();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++; $display("FAIL sb_left got %0d exp 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
